// File: rtl/etapa_mem_vectorial.sv
// etapa_mem_vectorial: vector memory stage splitting lane-packed vectors into per-element RAM accesses
module etapa_mem_vectorial #(
   parameter int LANES = 4,
   parameter int ELEM_W = 8,
   parameter int ADDR_W = 32,
   parameter int IMM_W = 8,
   parameter int DEST_W = 3,
   parameter int STRIDE_W = 8,
   localparam int VW = LANES*ELEM_W,
   localparam int VLW = $clog2(LANES+1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          op,
   input  logic [VLW-1:0]      vl_in,
   input  logic [STRIDE_W-1:0] stride_in,
   input  logic                sel_mem,
   input  logic                ptr_clear,
   input  logic                sel_data,
   input  logic [VW-1:0]       data1_in,
   input  logic [VW-1:0]       result_alu,
   input  logic [IMM_W-1:0]    inmediate_in,
   input  logic [DEST_W-1:0]   dir_dest_in,
   output logic                mem_req,
   output logic                mem_wr,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [ELEM_W-1:0]   mem_wdata,
   input  logic [ELEM_W-1:0]   mem_rdata,
   input  logic                mem_ack,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [VW-1:0]       mem_out,
   output logic [VW-1:0]       data,
   output logic [DEST_W-1:0]   dir_dest_out,
   output logic [IMM_W-1:0]    inmediate_out,
   output logic [ADDR_W-1:0]   pointer_out,
   output logic                busy
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state;
   logic [1:0] op_q;
   logic [VLW-1:0] vl_q, idx, vl_c;
   logic [STRIDE_W-1:0] stride_q;
   logic [ADDR_W-1:0] base_q;
   logic clr_q, go;
   assign vl_c = vl_in > VLW'(LANES) ? VLW'(LANES) : vl_in;
   assign go = (op == 2'b01 || op == 2'b10) && vl_c != '0;
   assign mem_addr = base_q + ADDR_W'(idx) * ADDR_W'(stride_q);
   assign mem_wdata = data[idx*ELEM_W +: ELEM_W];
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         op_q <= '0;
         vl_q <= '0;
         idx <= '0;
         stride_q <= '0;
         base_q <= '0;
         clr_q <= 1'b0;
         data <= '0;
         inmediate_out <= '0;
         dir_dest_out <= '0;
         mem_out <= '0;
         pointer_out <= '0;
         in_ready <= 1'b1;
         busy <= 1'b0;
         mem_req <= 1'b0;
         mem_wr <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               op_q <= op;
               vl_q <= vl_c;
               stride_q <= stride_in;
               base_q <= sel_mem ? ADDR_W'(inmediate_in) : pointer_out;
               data <= sel_data ? result_alu : data1_in;
               inmediate_out <= inmediate_in;
               dir_dest_out <= dir_dest_in;
               clr_q <= ptr_clear;
               mem_out <= '0;
               idx <= '0;
               state <= go ? ACCESS : DONE;
               mem_req <= go;
               mem_wr <= go && op == 2'b10;
               out_valid <= !go;
               in_ready <= 1'b0;
               busy <= 1'b1;
            end
            ACCESS: if (mem_ack) begin
               if (op_q == 2'b01) mem_out[idx*ELEM_W +: ELEM_W] <= mem_rdata;
               if (idx == vl_q - VLW'(1)) begin
                  state <= DONE;
                  mem_req <= 1'b0;
                  mem_wr <= 1'b0;
                  out_valid <= 1'b1;
               end else idx <= idx + VLW'(1);
            end
            DONE: if (out_ready) begin
               pointer_out <= clr_q ? '0 : base_q + ADDR_W'(vl_q) * ADDR_W'(stride_q);
               state <= IDLE;
               out_valid <= 1'b0;
               in_ready <= 1'b1;
               busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_etapa_mem_vectorial.sv
// tb_etapa_mem_vectorial: scoreboard bench with a queue-based reference model and a wait-state RAM
module tb_etapa_mem_vectorial;
   localparam int L = 4, EW = 8, AW = 16, IW = 8, DW = 3, SW = 8, VW = L*EW, VLW = $clog2(L+1);
   logic clk = 0, reset = 1, in_valid = 0, in_ready, sel_mem = 0, ptr_clear = 0, sel_data = 0;
   logic [1:0] op = '0;
   logic [VLW-1:0] vl_in = '0;
   logic [SW-1:0] stride_in = '0;
   logic [VW-1:0] data1_in = '0, result_alu = '0, mem_out, data;
   logic [IW-1:0] inmediate_in = '0, inmediate_out;
   logic [DW-1:0] dir_dest_in = '0, dir_dest_out;
   logic mem_req, mem_wr, mem_ack = 0, out_valid, out_ready = 1, busy;
   logic [AW-1:0] mem_addr, pointer_out;
   logic [EW-1:0] mem_wdata, mem_rdata = '0;
   int total = 0, bad = 0;
   typedef struct {logic [AW-1:0] addr; logic wr; logic [EW-1:0] wdata;} acc_t;
   typedef struct {logic [VW-1:0] mo; logic [VW-1:0] dt; logic [DW-1:0] dest; logic [IW-1:0] imm; logic [AW-1:0] ptr;} res_t;
   acc_t acc_q[$];
   res_t res_q[$];
   acc_t ma;
   res_t mr;
   logic [EW-1:0] ram[logic [AW-1:0]];
   logic [EW-1:0] ref_mem[logic [AW-1:0]];
   logic [AW-1:0] ref_ptr = '0, exp_ptr = '0;
   bit ptr_pend = 0;
   int wmode = 0, or_mode = 0, cnt = 0, tgt = 0;
   always #5 clk = ~clk;
   etapa_mem_vectorial #(.LANES(L), .ELEM_W(EW), .ADDR_W(AW), .IMM_W(IW), .DEST_W(DW), .STRIDE_W(SW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op), .vl_in(vl_in),
      .stride_in(stride_in), .sel_mem(sel_mem), .ptr_clear(ptr_clear), .sel_data(sel_data),
      .data1_in(data1_in), .result_alu(result_alu), .inmediate_in(inmediate_in), .dir_dest_in(dir_dest_in),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .out_valid(out_valid), .out_ready(out_ready), .mem_out(mem_out), .data(data),
      .dir_dest_out(dir_dest_out), .inmediate_out(inmediate_out), .pointer_out(pointer_out), .busy(busy));
   function automatic logic [EW-1:0] def_byte(logic [AW-1:0] a);
      return EW'(a + AW'(1));
   endfunction
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask
   // RAM: unwritten bytes read as addr+1; ack noise while idle must be ignored by the DUT
   initial forever begin
      @(posedge clk);
      #2;
      if (mem_req) begin
         if (cnt >= tgt) begin
            mem_ack = 1;
            mem_rdata = ram.exists(mem_addr) ? ram[mem_addr] : def_byte(mem_addr);
            cnt = 0;
            tgt = wmode < 0 ? int'($urandom_range(0, 2)) : wmode;
         end else begin
            mem_ack = 0;
            cnt++;
         end
      end else begin
         mem_ack = 1'($urandom);
         mem_rdata = EW'($urandom);
         cnt = 0;
         tgt = wmode < 0 ? int'($urandom_range(0, 2)) : wmode;
      end
      @(negedge clk);
      if (!reset && mem_req && mem_ack && mem_wr) ram[mem_addr] = mem_wdata;
   end
   initial forever begin
      @(posedge clk);
      #1;
      out_ready = or_mode == 2 ? 1'b0 : or_mode == 1 ? ($urandom_range(0, 3) != 0) : 1'b1;
   end
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         if (ptr_pend) begin
            chk("pointer", 64'(pointer_out), 64'(exp_ptr));
            ptr_pend = 0;
         end
         if (mem_req && mem_ack) begin
            if (acc_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_access: got addr %0h want no access", mem_addr);
            end else begin
               ma = acc_q.pop_front();
               chk("mem_addr", 64'(mem_addr), 64'(ma.addr));
               chk("mem_wr", 64'(mem_wr), 64'(ma.wr));
               if (ma.wr) chk("mem_wdata", 64'(mem_wdata), 64'(ma.wdata));
            end
         end
         if (out_valid && out_ready) begin
            if (res_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_result: got out_valid want none");
            end else begin
               mr = res_q.pop_front();
               chk("accesses_left", 64'(acc_q.size()), 64'(0));
               chk("mem_out", 64'(mem_out), 64'(mr.mo));
               chk("data", 64'(data), 64'(mr.dt));
               chk("dir_dest_out", 64'(dir_dest_out), 64'(mr.dest));
               chk("inmediate_out", 64'(inmediate_out), 64'(mr.imm));
               exp_ptr = mr.ptr;
               ptr_pend = 1;
            end
         end
      end
   end
   task automatic issue(logic [1:0] o, int v, int s, bit sm, bit pc, bit sd, logic [VW-1:0] d1,
                        logic [VW-1:0] alu, logic [IW-1:0] im, logic [DW-1:0] de);
      int n = 0;
      int vc;
      logic [AW-1:0] base, a;
      logic [VW-1:0] sel, mo;
      res_t r;
      while (!in_ready) begin
         @(posedge clk);
         #1;
         n++;
         if (n > 500) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got in_ready=0 want 1");
            return;
         end
      end
      op = o; vl_in = VLW'(v); stride_in = SW'(s); sel_mem = sm; ptr_clear = pc; sel_data = sd;
      data1_in = d1; result_alu = alu; inmediate_in = im; dir_dest_in = de; in_valid = 1;
      vc = v > L ? L : v;
      base = sm ? AW'(im) : ref_ptr;
      sel = sd ? alu : d1;
      mo = '0;
      if (o == 2'b01 || o == 2'b10) for (int i = 0; i < vc; i++) begin
         a = base + AW'(i * s);
         if (o == 2'b10) begin
            acc_q.push_back('{a, 1'b1, sel[i*EW +: EW]});
            ref_mem[a] = sel[i*EW +: EW];
         end else begin
            acc_q.push_back('{a, 1'b0, EW'(0)});
            mo[i*EW +: EW] = ref_mem.exists(a) ? ref_mem[a] : def_byte(a);
         end
      end
      r.mo = mo; r.dt = sel; r.dest = de; r.imm = im;
      r.ptr = pc ? AW'(0) : base + AW'(vc * s);
      res_q.push_back(r);
      ref_ptr = r.ptr;
      @(posedge clk);
      #1;
      in_valid = 0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while (res_q.size() != 0 || ptr_pend || !in_ready) begin
         @(posedge clk);
         #1;
         n++;
         if (n > 1000) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got %0d pending results want 0", res_q.size());
            return;
         end
      end
   endtask
   initial begin
      int n;
      logic [VW-1:0] s_mo, s_dt;
      logic [AW-1:0] s_p;
      logic [IW-1:0] s_im;
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_mem_req", 64'(mem_req), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_pointer", 64'(pointer_out), 64'(0));
      chk("rst_mem_out", 64'(mem_out), 64'(0));
      @(posedge clk);
      #1;
      issue(2'b10, 4, 1, 0, 0, 0, 32'hDDCCBBAA, 32'h0, 8'h0, 3'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("store_back_to_back", 64'({mem_req, mem_ack}), 64'(2'b11));
      end
      @(negedge clk);
      chk("store_out_valid", 64'(out_valid), 64'(1));
      wait_idle();
      chk("store_pointer", 64'(pointer_out), 64'(4));
      wmode = 2;
      issue(2'b01, 3, 2, 1, 0, 0, VW'($urandom), VW'($urandom), 8'h10, 3'd2);
      wait_idle();
      chk("load_mem_out", 64'(mem_out), 64'(32'h00151311));
      chk("load_pointer", 64'(pointer_out), 64'(16'h16));
      wmode = 0;
      issue(2'b00, 4, 3, 0, 1, 1, 32'h11111111, 32'hCAFEF00D, 8'h05, 3'd3);
      @(negedge clk);
      chk("none_out_valid_t1", 64'(out_valid), 64'(1));
      chk("none_no_req", 64'(mem_req), 64'(0));
      chk("none_data_alu", 64'(data), 64'(32'hCAFEF00D));
      wait_idle();
      chk("none_ptr_clear", 64'(pointer_out), 64'(0));
      or_mode = 2;
      @(posedge clk);
      #2;
      issue(2'b10, 2, 1, 0, 0, 1, VW'($urandom), VW'($urandom), IW'($urandom), 3'd5);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 50);
      chk("hold_reach_done", 64'(out_valid), 64'(1));
      s_mo = mem_out; s_dt = data; s_p = pointer_out; s_im = inmediate_out;
      @(posedge clk);
      #1;
      in_valid = 1; op = 2'b01; vl_in = VLW'(4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_in_ready", 64'(in_ready), 64'(0));
         chk("hold_out_valid", 64'(out_valid), 64'(1));
         chk("hold_data", 64'(data), 64'(s_dt));
         chk("hold_mem_out", 64'(mem_out), 64'(s_mo));
         chk("hold_pointer", 64'(pointer_out), 64'(s_p));
         chk("hold_imm", 64'(inmediate_out), 64'(s_im));
      end
      @(posedge clk);
      #1;
      in_valid = 0;
      or_mode = 0;
      wait_idle();
      issue(2'b00, 0, 0, 0, 1, 0, '0, '0, '0, '0);
      for (int i = 0; i < 64; i++) issue(2'b11, 4, 255, 0, 0, 0, '0, '0, '0, '0);
      issue(2'b00, 2, 127, 0, 0, 0, '0, '0, '0, '0);
      wait_idle();
      chk("wrap_ptr_top", 64'(pointer_out), 64'(16'hFFFE));
      issue(2'b10, 4, 1, 0, 0, 0, VW'($urandom), '0, '0, 3'd4);
      wait_idle();
      chk("wrap_ptr_after", 64'(pointer_out), 64'(2));
      wmode = -1;
      or_mode = 1;
      for (int i = 0; i < 80; i++)
         issue(2'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), 1'($urandom),
               $urandom_range(0, 7) == 0, 1'($urandom), VW'($urandom), VW'($urandom), IW'($urandom), DW'($urandom));
      or_mode = 0;
      wait_idle();
      wmode = 2;
      issue(2'b01, 4, 3, 1, 0, 0, '0, '0, 8'h80, 3'd1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(mem_req && mem_addr == 16'h83) && n < 100);
      chk("rst_mid_reach_elem1", 64'(mem_addr), 64'(16'h83));
      @(posedge clk);
      #1;
      reset = 1;
      acc_q.delete();
      res_q.delete();
      ptr_pend = 0;
      @(posedge clk);
      #1;
      reset = 0;
      ref_ptr = '0;
      @(negedge clk);
      chk("rst_mid_mem_req", 64'(mem_req), 64'(0));
      chk("rst_mid_busy", 64'(busy), 64'(0));
      chk("rst_mid_pointer", 64'(pointer_out), 64'(0));
      chk("rst_mid_in_ready", 64'(in_ready), 64'(1));
      wmode = 0;
      issue(2'b10, 3, 1, 1, 0, 0, 32'h00332211, '0, 8'hA0, 3'd6);
      wait_idle();
      chk("post_rst_pointer", 64'(pointer_out), 64'(16'hA3));
      chk("final_accesses_left", 64'(acc_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish before 2000000");
      $fatal(1);
   end
endmodule

// File: doc/etapa_mem_vectorial.md
# etapa_mem_vectorial

Parametrised vector memory stage that sits between the EX/MEM and MEM/WB pipeline registers. It accepts one memory operation per handshake and splits a lane-packed vector into per-element RAM accesses. Element addresses are generated from a base plus a stride, where the base is either a persistent pointer register or a zero-extended immediate. Loaded elements are packed back into a vector, and the result is presented to MEM/WB with a valid/ready handshake. The pointer register is post-incremented or cleared on completion.

## Interface
- LANES, 4, elements per vector
- ELEM_W, 8, element and RAM data width; vector width VW = LANES*ELEM_W
- ADDR_W, 32, RAM address and pointer width
- IMM_W, 8, immediate width
- DEST_W, 3, destination register index width
- STRIDE_W, 8, unsigned element stride width
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid / in_ready  in / out  1 / 1  operation handshake from EX/MEM
- op  in  2  00 none, 01 load, 10 store, 11 treated as none
- vl_in  in  $clog2(LANES+1)  active lanes, lanes 0..vl_in-1; values above LANES clamp to LANES
- stride_in  in  STRIDE_W  address step between elements
- sel_mem  in  1  base select: 0 pointer register, 1 zero-extended inmediate_in
- ptr_clear  in  1  on completion: 1 clears the pointer, 0 post-increments it
- sel_data  in  1  0 selects data1_in, 1 selects result_alu (store data and pass-through)
- data1_in, result_alu  in  VW  lane-packed vectors, lane i = bits [i*ELEM_W +: ELEM_W]
- inmediate_in  in  IMM_W  immediate
- dir_dest_in  in  DEST_W  destination register
- mem_req  out  1  RAM request
- mem_wr  out  1  1 write, 0 read; meaningful while mem_req=1
- mem_addr  out  ADDR_W  element address
- mem_wdata  out  ELEM_W  store element
- mem_rdata  in  ELEM_W  read data, valid together with mem_ack
- mem_ack  in  1  access complete; ignored while mem_req=0
- out_valid / out_ready  out / in  1 / 1  result handshake to MEM/WB
- mem_out  out  VW  loaded vector; inactive lanes are 0
- data  out  VW  selected data vector (latched)
- dir_dest_out  out  DEST_W  latched dir_dest_in
- inmediate_out  out  IMM_W  latched inmediate_in
- pointer_out  out  ADDR_W  current pointer register value
- busy  out  1  state != IDLE

## Operation
- The FSM has three states: IDLE, ACCESS and DONE. in_ready = (state == IDLE).
- IDLE: an accept happens when in_valid and in_ready are both 1.
  - On accept, latch op, the clamped vl, stride, the base, the selected data, inmediate_in, dir_dest_in and ptr_clear.
  - Clear the load buffer and set idx = 0.
  - If op is none or vl = 0, go to DONE. Otherwise go to ACCESS.
- ACCESS: drive the RAM port as follows.
  - mem_req = 1.
  - mem_wr = (op == store).
  - mem_addr = base + idx*stride, computed modulo 2^ADDR_W.
  - mem_wdata = lane idx of the latched data.
  - On mem_ack, a load writes mem_rdata into lane idx. If idx = vl-1, go to DONE; otherwise idx increments.
  - All outputs are held stable until mem_ack.
- DONE: out_valid = 1, with every output held until out_ready.
  - On the out_valid/out_ready handshake, update the pointer: ptr_clear=1 gives pointer = 0; otherwise pointer = base + vl*stride (mod 2^ADDR_W). Then go to IDLE.
  - With op none, the pointer is still updated with vl*stride. This makes it usable as an address-advance op.
- The pointer register changes only at the DONE handshake or on reset.
- Reset values: state IDLE, pointer 0, idx 0, and all registered outputs 0. As a result in_ready=1, mem_req=0, out_valid=0 and busy=0.
- Reset mid-operation aborts the operation and the pointer is not updated. mem_ack arriving in the reset cycle is ignored.

## Timing
- Accept is at edge T, and the first mem_req is asserted in cycle T+1.
- Each element takes 1 cycle plus the RAM wait cycles. With a zero-wait RAM (mem_ack in the same cycle as mem_req), vl elements take vl cycles.
- out_valid rises the cycle after the last ack. For a non-memory op or vl = 0 it rises at T+1.
- Minimum issue interval with a zero-wait RAM and out_ready=1: vl+2 cycles, or 2 cycles for a non-memory op.
- Outputs are registered, except mem_addr and mem_wdata. These are combinational from registered state only and do not depend on the current-cycle inputs.
- Inputs are ignored while in_ready = 0.

## Test plan
- Reset, then store with vl=4, stride=1, sel_mem=0, data1_in=32'hDDCCBBAA, zero-wait RAM: writes AA@0, BB@1, CC@2, DD@3 in 4 consecutive cycles. out_valid follows, then pointer_out = 4.
- Load with vl=3, sel_mem=1, inmediate_in=8'h10, stride=2, RAM returning addr+1 with 2 wait cycles per element: reads 0x10, 0x12, 0x14. mem_out = 32'h00151311, and the pointer becomes 0x16.
- Op none with ptr_clear=1 after the pointer reaches 0x16: no mem_req, out_valid at T+1, then pointer_out = 0. data equals result_alu when sel_data=1.
- Hold out_ready=0 for 5 cycles in DONE: outputs are stable, in_valid is refused (in_ready=0), and the pointer is unchanged until the handshake.
- Pointer = 0xFFFFFFFE, stride=1, vl=4: addresses FFFFFFFE, FFFFFFFF, 0, 1, then pointer = 2.
- Assert reset during the 2nd element of vl=4: the next cycle shows mem_req=0, busy=0 and pointer = 0. A following op works normally.
